mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter_req_buf.sv | 30 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32i_types;

    typedef enum logic [1:0] {
        arb_idle    = 2'd0,
        arb_serve_i = 2'd1,
        arb_serve_d = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_NONE = '0;

    // A request is live whenever either byte mask is nonzero.
    function automatic logic req_live(input mem_req_t r);
        return (|r.rmask) || (|r.wmask);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the imem, dmem and shared memory port signals.
// Latency: n/a (wires only).
// Backpressure: none; requests are one-cycle pulses, completions are one-cycle pulses.
interface mem_port_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Requesters and the memory drive this side.
    modport master (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output mem_rdata, mem_resp,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata
    );

    // The arbiter sits on this side.
    modport slave (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  mem_rdata, mem_resp,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_req_buf.sv
// One-entry holding register for a request that could not issue on arrival.
// Latency: captured request is visible the cycle after load.
// Backpressure: none; the requester protocol guarantees it is never loaded while full.
module mem_req_buf
    import rv32i_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  mem_req_t din,
    output logic     vld,
    output mem_req_t dat
);

    // Load takes precedence over clear; both fields return to zero when emptied.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= MEM_REQ_NONE;
        end else if (load) begin
            vld <= 1'b1;
            dat <= din;
        end else if (clear) begin
            vld <= 1'b0;
            dat <= MEM_REQ_NONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between imem and dmem, dmem first, one request outstanding.
// Latency: zero added cycles when idle; held requests issue the cycle after mem_resp.
// Backpressure: none; a request that cannot issue is parked in its one-entry buffer.
module mem_port_arbiter
    import rv32i_types::*;
(
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state;
    arb_state_t state_next;

    mem_req_t i_live_req;
    mem_req_t d_live_req;
    mem_req_t i_pend;
    mem_req_t d_pend;
    mem_req_t i_cand;
    mem_req_t d_cand;
    mem_req_t issue_req;
    logic     i_live;
    logic     d_live;
    logic     i_pend_vld;
    logic     d_pend_vld;
    logic     i_has;
    logic     d_has;
    logic     issue_i;
    logic     issue_d;
    logic     i_resp;
    logic     d_resp;
    logic     i_load;
    logic     i_clear;
    logic     d_load;
    logic     d_clear;

    // Instruction fetches never write, so their write fields are tied off here.
    assign i_live_req = '{addr: bus.imem_addr, rmask: bus.imem_rmask, wmask: 4'h0, wdata: 32'h0};
    assign d_live_req = '{addr: bus.dmem_addr, rmask: bus.dmem_rmask,
                          wmask: bus.dmem_wmask, wdata: bus.dmem_wdata};

    // Requests seen while in reset are dropped outright.
    assign i_live = !rst && req_live(i_live_req);
    assign d_live = !rst && req_live(d_live_req);

    // A held entry is always older than a live one from the same requester.
    assign i_cand = i_pend_vld ? i_pend : i_live_req;
    assign d_cand = d_pend_vld ? d_pend : d_live_req;
    assign i_has  = i_pend_vld || i_live;
    assign d_has  = d_pend_vld || d_live;

    // Park any live request that did not go out this cycle; free the entry once it issues.
    assign i_load  = i_live && !(issue_i && !i_pend_vld);
    assign i_clear = issue_i && i_pend_vld;
    assign d_load  = d_live && !(issue_d && !d_pend_vld);
    assign d_clear = issue_d && d_pend_vld;

    mem_req_buf u_i_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (i_load),
        .clear (i_clear),
        .din   (i_live_req),
        .vld   (i_pend_vld),
        .dat   (i_pend)
    );

    mem_req_buf u_d_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (d_load),
        .clear (d_clear),
        .din   (d_live_req),
        .vld   (d_pend_vld),
        .dat   (d_pend)
    );

    // State register; reset abandons any outstanding memory access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= arb_idle;
        end else begin
            state <= state_next;
        end
    end

    // Grant from idle only (dmem first), complete on mem_resp, never issue on a resp cycle.
    always_comb begin
        state_next = state;
        issue_i    = 1'b0;
        issue_d    = 1'b0;
        issue_req  = MEM_REQ_NONE;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        if (!rst) begin
            unique case (state)
                arb_idle: begin
                    if (d_has) begin
                        issue_d    = 1'b1;
                        issue_req  = d_cand;
                        state_next = arb_serve_d;
                    end else if (i_has) begin
                        issue_i    = 1'b1;
                        issue_req  = i_cand;
                        state_next = arb_serve_i;
                    end
                end
                arb_serve_i: begin
                    if (bus.mem_resp) begin
                        i_resp     = 1'b1;
                        state_next = arb_idle;
                    end
                end
                arb_serve_d: begin
                    if (bus.mem_resp) begin
                        d_resp     = 1'b1;
                        state_next = arb_idle;
                    end
                end
                default: state_next = arb_idle;
            endcase
        end
    end

    assign bus.mem_addr   = issue_req.addr;
    assign bus.mem_rmask  = issue_req.rmask;
    assign bus.mem_wmask  = issue_req.wmask;
    assign bus.mem_wdata  = issue_req.wdata;
    assign bus.imem_resp  = i_resp;
    assign bus.dmem_resp  = d_resp;
    assign bus.imem_rdata = bus.mem_rdata;
    assign bus.dmem_rdata = bus.mem_rdata;

    // A requester may only raise a new request once it is neither parked nor in flight;
    // the completing cycle itself is allowed.
    a_imem_protocol: assert property (@(posedge clk) disable iff (rst)
        !(i_live && (i_pend_vld || (state == arb_serve_i && !bus.mem_resp))));
    a_dmem_protocol: assert property (@(posedge clk) disable iff (rst)
        !(d_live && (d_pend_vld || (state == arb_serve_d && !bus.mem_resp))));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int       cyc;
        mem_req_t req;
    } exp_iss_t;

    typedef struct {
        int          cyc;
        bit          side;   // 0 = imem, 1 = dmem
        logic [31:0] rdata;
    } exp_rsp_t;

    exp_iss_t exp_iss[$];
    exp_rsp_t exp_rsp[$];

    // Reference model: per-requester FIFOs of waiting requests plus one busy slot.
    mem_req_t iq[$];
    mem_req_t dq[$];
    bit       busy;
    bit       busy_side;
    int       busy_cnt;
    int       cyc;
    int       delay;
    bit       force_resp;

    int n_tests;
    int n_fail;
    bit outstanding;

    mem_req_t mon_got;
    bit       mon_iss;
    exp_iss_t mon_ei;
    exp_rsp_t mon_er;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic mem_req_t ireq(input logic [31:0] a, input logic [3:0] rm);
        return '{addr: a, rmask: rm, wmask: 4'h0, wdata: 32'h0};
    endfunction

    function automatic mem_req_t dreq(input logic [31:0] a, input logic [3:0] rm,
                                      input logic [3:0] wm, input logic [31:0] wd);
        return '{addr: a, rmask: rm, wmask: wm, wdata: wd};
    endfunction

    function automatic bit can_i();
        return iq.size() == 0 && !(busy && !busy_side && busy_cnt != 1);
    endfunction

    function automatic bit can_d();
        return dq.size() == 0 && !(busy && busy_side && busy_cnt != 1);
    endfunction

    // One clock cycle: called just after a falling edge, returns at the next falling edge.
    task automatic step(input bit i_go, input mem_req_t ir, input bit d_go, input mem_req_t dr);
        bit       was_busy;
        bit       resp_now;
        mem_req_t r;
        cyc++;
        resp_now       = 1'b0;
        bus.mem_resp   = 1'b0;
        bus.mem_rdata  = $urandom;
        bus.imem_addr  = $urandom;
        bus.imem_rmask = 4'h0;
        bus.dmem_addr  = $urandom;
        bus.dmem_rmask = 4'h0;
        bus.dmem_wmask = 4'h0;
        bus.dmem_wdata = $urandom;
        if (i_go) begin
            bus.imem_addr  = ir.addr;
            bus.imem_rmask = ir.rmask;
        end
        if (d_go) begin
            bus.dmem_addr  = dr.addr;
            bus.dmem_rmask = dr.rmask;
            bus.dmem_wmask = dr.wmask;
            bus.dmem_wdata = dr.wdata;
        end
        if (rst) begin
            iq.delete();
            dq.delete();
            busy     = 1'b0;
            busy_cnt = 0;
            if (force_resp) bus.mem_resp = 1'b1;
        end else begin
            was_busy = busy;
            if (was_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    resp_now     = 1'b1;
                    bus.mem_resp = 1'b1;
                    exp_rsp.push_back('{cyc: cyc, side: busy_side, rdata: bus.mem_rdata});
                end
            end else if (force_resp) begin
                bus.mem_resp = 1'b1;
            end
            if (i_go) iq.push_back(ir);
            if (d_go) dq.push_back(dr);
            if (!was_busy && (dq.size() != 0 || iq.size() != 0)) begin
                if (dq.size() != 0) begin
                    r         = dq.pop_front();
                    busy_side = 1'b1;
                end else begin
                    r         = iq.pop_front();
                    busy_side = 1'b0;
                end
                exp_iss.push_back('{cyc: cyc, req: r});
                busy     = 1'b1;
                busy_cnt = delay;
            end
            if (resp_now) busy = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, MEM_REQ_NONE, 1'b0, MEM_REQ_NONE);
    endtask

    // Monitor: samples settled outputs between the falling and rising edges.
    always @(negedge clk) begin
        #2;
        mon_got = '{addr: bus.mem_addr, rmask: bus.mem_rmask, wmask: bus.mem_wmask, wdata: bus.mem_wdata};
        mon_iss = (|bus.mem_rmask) || (|bus.mem_wmask);
        if (mon_iss) begin
            check("overlap", {71'h0, outstanding}, 72'h0);
            n_tests++;
            if (exp_iss.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_issue (cycle %0d): got request %h expected none", cyc, mon_got);
            end else begin
                mon_ei = exp_iss.pop_front();
                check("issue_cycle", 72'(cyc), 72'(mon_ei.cyc));
                check("issue_req", mon_got, mon_ei.req);
            end
        end else begin
            check("idle_bus", {8'h0, bus.mem_addr, bus.mem_wdata}, 72'h0);
        end
        if (rst) outstanding = 1'b0;
        else     outstanding = mon_iss ? 1'b1 : (bus.mem_resp ? 1'b0 : outstanding);
        check("rdata_pass", {8'h0, bus.imem_rdata, bus.dmem_rdata}, {8'h0, bus.mem_rdata, bus.mem_rdata});
        if (bus.imem_resp || bus.dmem_resp) begin
            n_tests++;
            if (exp_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_resp (cycle %0d): got imem_resp=%0b dmem_resp=%0b expected none",
                         cyc, bus.imem_resp, bus.dmem_resp);
            end else begin
                mon_er = exp_rsp.pop_front();
                check("resp_cycle", 72'(cyc), 72'(mon_er.cyc));
                check("resp_side", {70'h0, bus.imem_resp, bus.dmem_resp},
                      mon_er.side ? 72'h1 : 72'h2);
                check("resp_data", {40'h0, (bus.imem_resp ? bus.imem_rdata : bus.dmem_rdata)},
                      {40'h0, mon_er.rdata});
            end
        end
    end

    initial begin
        int nreq;
        bit ig;
        bit dg;
        mem_req_t ir;
        mem_req_t dr;

        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        busy    = 1'b0;
        delay   = 2;
        force_resp  = 1'b0;
        outstanding = 1'b0;
        bus.imem_addr  = '0;
        bus.imem_rmask = '0;
        bus.dmem_addr  = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Requests and a stray mem_resp during reset must all be ignored.
        force_resp = 1'b1;
        step(1'b1, ireq(32'h1234_5678, 4'hF), 1'b1, dreq(32'h0000_0010, 4'hF, 4'h0, 32'h0));
        step(1'b1, ireq(32'h1234_5678, 4'hF), 1'b1, dreq(32'h0000_0010, 4'hF, 4'h0, 32'h0));
        force_resp = 1'b0;
        rst = 1'b0;
        idle(3);

        // Single fetch, completion three cycles after issue.
        delay = 3;
        step(1'b1, ireq(32'h1ece_b000, 4'hF), 1'b0, MEM_REQ_NONE);
        idle(5);

        // Simultaneous fetch and store: store goes first, fetch right after its resp.
        delay = 2;
        step(1'b1, ireq(32'h0000_0100, 4'hF), 1'b1, dreq(32'h0000_0200, 4'h0, 4'h3, 32'hA5A5_0F0F));
        idle(8);

        // Data read arriving while a fetch is in flight.
        step(1'b1, ireq(32'h0000_0300, 4'hF), 1'b0, MEM_REQ_NONE);
        step(1'b0, MEM_REQ_NONE, 1'b1, dreq(32'h0000_0040, 4'hF, 4'h0, 32'h0));
        idle(6);

        // Fetch re-requests on the very cycle its previous access completes.
        step(1'b1, ireq(32'h0000_0500, 4'hF), 1'b0, MEM_REQ_NONE);
        idle(1);
        step(1'b1, ireq(32'h0000_0504, 4'h3), 1'b0, MEM_REQ_NONE);
        idle(5);

        // Reset in the middle of a data access, then a late mem_resp.
        delay = 6;
        step(1'b0, MEM_REQ_NONE, 1'b1, dreq(32'h0000_0080, 4'hF, 4'h0, 32'h0));
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        force_resp = 1'b1;
        idle(1);
        force_resp = 1'b0;
        idle(1);
        delay = 2;
        step(1'b1, ireq(32'h0000_0600, 4'hF), 1'b0, MEM_REQ_NONE);
        idle(4);

        // Random mixed traffic.
        nreq = 0;
        for (int c = 0; c < 20000 && nreq < 1000; c++) begin
            delay = $urandom_range(1, 4);
            ig = can_i() && ($urandom_range(0, 2) != 0);
            dg = can_d() && ($urandom_range(0, 2) != 0);
            ir = ireq($urandom, 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 1) == 0)
                dr = dreq($urandom, 4'($urandom_range(1, 15)), 4'h0, $urandom);
            else
                dr = dreq($urandom, 4'h0, 4'($urandom_range(1, 15)), $urandom);
            nreq += int'(ig) + int'(dg);
            step(ig, ir, dg, dr);
        end

        for (int k = 0; k < 50 && (busy || iq.size() != 0 || dq.size() != 0); k++) idle(1);
        check("drain_timeout", {71'h0, (busy || iq.size() != 0 || dq.size() != 0)}, 72'h0);
        idle(2);
        check("issues_left", 72'(exp_iss.size()), 72'h0);
        check("resps_left", 72'(exp_rsp.size()), 72'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
